// File: rtl/step_dispatcher.sv
// step_dispatcher: FIFO-buffered operand issuer for step_controller with a registered result stream
// Ports: clk, rst_n (synchronous, active-low); in_valid/in_ready/in_data operand stream;
//   ctl_start/ctl_data/ctl_done/ctl_result controller handshake;
//   out_valid/out_ready/out_data/out_err result stream; busy (FSM not idle); count (FIFO occupancy).
// Option macro STEP_DISPATCH_TIMEOUT_EN: WAIT watchdog aborts a job after TIMEOUT cycles with out_err=1.
module step_dispatcher #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic ctl_start,
  output logic [DATA_W-1:0] ctl_data,
  input  logic ctl_done,
  input  logic [DATA_W-1:0] ctl_result,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic out_err,
  output logic busy,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_OUT = 2'd3;
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);
  logic [1:0] r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_count;
  logic [DATA_W-1:0] r_ctl_data, r_out_data;
  logic w_push, w_pop, w_timeout, w_finish;
  // in_ready comes from the registered count, so a full FIFO refuses even on a pop edge
  assign w_push = in_valid && in_ready;
  assign w_pop = r_state == S_IDLE && r_count != '0;
  assign w_finish = r_state == S_WAIT && (ctl_done || w_timeout);
  assign in_ready = r_count < L_FULL;
  assign ctl_start = r_state == S_ISSUE;
  assign ctl_data = r_ctl_data;
  assign out_valid = r_state == S_OUT;
  assign out_data = r_out_data;
  assign busy = r_state != S_IDLE;
  assign count = r_count;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      r_ctl_data <= '0;
      r_out_data <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_pop) r_ctl_data <= r_mem[r_rp];
      // a real completion wins over a watchdog expiry on the same edge
      if (w_finish) r_out_data <= ctl_done ? ctl_result : '1;
      case (r_state)
        S_IDLE:  if (w_pop) r_state <= S_ISSUE;
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT:  if (w_finish) r_state <= S_OUT;
        default: if (out_ready) r_state <= S_IDLE;
      endcase
    end
  end
`ifdef STEP_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wd;
  logic r_out_err;
  // r_wd counts completed WAIT cycles; expiry on the TIMEOUT-th one
  assign w_timeout = r_state == S_WAIT && r_wd == TW'(TIMEOUT - 1);
  assign out_err = r_out_err;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd <= '0;
      r_out_err <= 1'b0;
    end else begin
      r_wd <= r_state == S_WAIT ? r_wd + 1'b1 : '0;
      if (w_finish) r_out_err <= !ctl_done;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_step_dispatcher.sv
// tb_step_dispatcher: randomized self-checking bench for step_dispatcher against a queue-based reference model
module tb_step_dispatcher;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  localparam logic [23:0] RST_VEC = {3'd0, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic ctl_start;
  logic [DW-1:0] ctl_data;
  logic ctl_done = 1'b0;
  logic [DW-1:0] ctl_result = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic out_err;
  logic busy;
  logic [$clog2(DEPTH):0] count;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q_push[$];
  logic [DW-1:0] q_start[$];
  logic [DW-1:0] q_out[$];
  logic q_err[$];
  int outstanding = 0;
  int n_overlap = 0;
  int n_long = 0;
  int n_unstable = 0;
  logic prev_start = 1'b0;
  logic [DW-1:0] cur_op = '0;
  int lat_lo = 3;
  int lat_hi = 3;
  bit hang = 1'b0;

  step_dispatcher #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ctl_start(ctl_start), .ctl_data(ctl_data), .ctl_done(ctl_done), .ctl_result(ctl_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  // controller transfer function
  function automatic logic [DW-1:0] f(input logic [DW-1:0] x);
    return DW'(x * 3 + 13);
  endfunction

  // controller model: done pulses a random number of edges after start is sampled
  initial begin : ctl_model
    int cnt;
    bit pend;
    logic [DW-1:0] op;
    cnt = 0;
    pend = 1'b0;
    op = '0;
    forever begin
      @(posedge clk);
      #1;
      ctl_done = 1'b0;
      ctl_result = DW'($urandom);
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 1'b0;
            if (!hang) begin
              ctl_done = 1'b1;
              ctl_result = f(op);
            end
          end
        end
        if (ctl_start) begin
          pend = 1'b1;
          op = ctl_data;
          cnt = $urandom_range(lat_hi, lat_lo);
        end
      end
    end
  end

  // event recorder: what the next rising edge will do
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_start = 1'b0;
    end else begin
      if (in_valid && in_ready) q_push.push_back(in_data);
      if (ctl_start) begin
        if (outstanding != 0) n_overlap++;
        if (prev_start) n_long++;
        q_start.push_back(ctl_data);
        cur_op = ctl_data;
        outstanding++;
      end else if (outstanding != 0 && !out_valid && ctl_data !== cur_op) n_unstable++;
      if (out_valid && out_ready) begin
        q_out.push_back(out_data);
        q_err.push_back(out_err);
        outstanding--;
      end
      prev_start = ctl_start;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    q_push.delete();
    q_start.delete();
    q_out.delete();
    q_err.delete();
  endtask

  task automatic push(input logic [DW-1:0] v);
    bit ok;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = v;
    do begin
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 200);
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: in_ready low for %0d cycles, required accept of %0h", n, v);
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (q_out.size() < n && t < 1000) begin
      step();
      t++;
    end
    checks++;
    if (q_out.size() < n) begin
      errors++;
      $display("FAIL wait_out: got %0d results, required %0d", q_out.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({count, in_ready, ctl_start, ctl_data, out_valid, out_data, out_err, busy} !== RST_VEC) begin
      errors++;
      $display("FAIL reset_state: got %h required %h",
               {count, in_ready, ctl_start, ctl_data, out_valid, out_data, out_err, busy}, RST_VEC);
    end
    rst_n = 1'b1;
    step();
    clear();
  endtask

  task automatic test_single();
    int t;
    clear();
    lat_lo = 3;
    lat_hi = 3;
    out_ready = 1'b1;
    push(8'd10);
    t = 0;
    while (!out_valid && t < 50) begin
      step();
      t++;
    end
    checks++;
    if (t != 2 + 3) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, required %0d", t, 2 + 3);
    end
    wait_out(1);
    checks++;
    if (q_start.size() != 1 || q_start[0] !== 8'd10) begin
      errors++;
      $display("FAIL single_start: got %0d starts first %0h, required 1 start of 0a", q_start.size(), q_start[0]);
    end
    checks++;
    if (q_out.size() != 1 || q_out[0] !== 8'd43 || q_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got %0h err %b, required 2b err 0", q_out[0], q_err[0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy %b, required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    clear();
    lat_lo = 6;
    lat_hi = 6;
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) push(DW'(v));
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0 || q_start.size() != 1) begin
      errors++;
      $display("FAIL bp_full: count %0d in_ready %b starts %0d, required 4 0 1", count, in_ready, q_start.size());
    end
    in_valid = 1'b1;
    in_data = 8'd99;
    out_ready = 1'b1;
    wait_out(1);
    step();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL bp_full_pop_refuse: count %0d, required 3", count);
    end
    wait_out(5);
    for (int i = 0; i < 5 && i < q_out.size(); i++) begin
      checks++;
      if (q_out[i] !== f(DW'(i + 1)) || q_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %0h err %b, required %0h err 0", i, q_out[i], q_err[i], f(DW'(i + 1)));
      end
    end
    checks++;
    if (q_push.size() != 5 || n_overlap != 0) begin
      errors++;
      $display("FAIL bp_accept_overlap: pushes %0d overlaps %0d, required 5 0", q_push.size(), n_overlap);
    end
  endtask

  task automatic test_out_stall();
    int t;
    bit stable;
    logic [DW-1:0] d0;
    clear();
    lat_lo = 2;
    lat_hi = 2;
    out_ready = 1'b0;
    push(8'd7);
    push(8'd8);
    t = 0;
    while (!out_valid && t < 50) begin
      step();
      t++;
    end
    d0 = out_data;
    stable = 1'b1;
    repeat (10) begin
      step();
      if (!out_valid || out_data !== d0 || q_start.size() != 1) stable = 1'b0;
    end
    checks++;
    if (!stable || d0 !== f(8'd7)) begin
      errors++;
      $display("FAIL stall_hold: stable %b data %0h starts %0d, required 1 %0h 1", stable, d0, q_start.size(), f(8'd7));
    end
    out_ready = 1'b1;
    wait_out(2);
    checks++;
    if (q_out.size() != 2 || q_out[0] !== f(8'd7) || q_out[1] !== f(8'd8) || q_start.size() != 2 || n_overlap != 0) begin
      errors++;
      $display("FAIL stall_results: got %0h %0h starts %0d overlaps %0d, required %0h %0h 2 0",
               q_out[0], q_out[1], q_start.size(), n_overlap, f(8'd7), f(8'd8));
    end
  endtask

  task automatic test_same_edge();
    logic [DW-1:0] a, b;
    clear();
    lat_lo = 1;
    lat_hi = 1;
    out_ready = 1'b1;
    a = DW'($urandom);
    b = DW'($urandom);
    push(a);
    push(b);
    checks++;
    if (count !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_count: count %0d busy %b, required 1 1", count, busy);
    end
    wait_out(2);
    checks++;
    if (q_out.size() != 2 || q_out[0] !== f(a) || q_out[1] !== f(b)) begin
      errors++;
      $display("FAIL same_edge_results: got %0h %0h, required %0h %0h", q_out[0], q_out[1], f(a), f(b));
    end
  endtask

  task automatic test_random();
    int t;
    int n;
    n = 40;
    clear();
    lat_lo = 1;
    lat_hi = 4;
    t = 0;
    while (q_out.size() < n && t < 4000) begin
      in_valid = q_push.size() < n && $urandom_range(3, 0) != 0;
      in_data = DW'($urandom);
      out_ready = 1'($urandom_range(1, 0));
      step();
      t++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (q_out.size() != n || q_push.size() != n || q_start.size() != n) begin
      errors++;
      $display("FAIL random_count: results %0d pushes %0d starts %0d, required %0d", q_out.size(), q_push.size(), q_start.size(), n);
    end
    for (int i = 0; i < q_out.size() && i < q_push.size() && i < q_start.size(); i++) begin
      checks++;
      if (q_out[i] !== f(q_push[i]) || q_err[i] !== 1'b0 || q_start[i] !== q_push[i]) begin
        errors++;
        $display("FAIL random_job[%0d]: start %0h result %0h err %b, required start %0h result %0h err 0",
                 i, q_start[i], q_out[i], q_err[i], q_push[i], f(q_push[i]));
      end
    end
    checks++;
    if (n_overlap != 0 || n_long != 0 || n_unstable != 0) begin
      errors++;
      $display("FAIL random_protocol: overlaps %0d long_starts %0d unstable %0d, required 0 0 0", n_overlap, n_long, n_unstable);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear();
    lat_lo = 2;
    lat_hi = 2;
    hang = 1'b1;
    out_ready = 1'b1;
    push(8'd11);
    push(8'd22);
    push(8'd33);
    repeat (2) step();
    checks++;
    if (busy !== 1'b1 || count !== 3'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: busy %b count %0d out_valid %b, required 1 2 0", busy, count, out_valid);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({count, in_ready, ctl_start, ctl_data, out_valid, out_data, out_err, busy} !== RST_VEC) begin
      errors++;
      $display("FAIL midreset_state: got %h required %h",
               {count, in_ready, ctl_start, ctl_data, out_valid, out_data, out_err, busy}, RST_VEC);
    end
    rst_n = 1'b1;
    hang = 1'b0;
    clear();
    repeat (20) step();
    checks++;
    if (q_out.size() != 0 || q_start.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stale: results %0d starts %0d busy %b, required 0 0 0", q_out.size(), q_start.size(), busy);
    end
    push(8'd44);
    wait_out(1);
    checks++;
    if (q_out.size() != 1 || q_out[0] !== f(8'd44) || q_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next: got %0h err %b, required %0h err 0", q_out[0], q_err[0], f(8'd44));
    end
  endtask

`ifdef STEP_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    clear();
    hang = 1'b1;
    out_ready = 1'b0;
    push(8'h55);
    t = 0;
    while (!out_valid && t < 200) begin
      step();
      t++;
    end
    checks++;
    if (t != 2 + TO || out_data !== 8'hFF || out_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: cycles %0d data %0h err %b, required %0d ff 1", t, out_data, out_err, 2 + TO);
    end
    out_ready = 1'b1;
    wait_out(1);
    hang = 1'b0;
    lat_lo = 3;
    lat_hi = 3;
    push(8'd66);
    wait_out(2);
    checks++;
    if (q_out.size() != 2 || q_out[1] !== f(8'd66) || q_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next: got %0h err %b, required %0h err 0", q_out[1], q_err[1], f(8'd66));
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_out_stall();
    test_same_edge();
    test_random();
    test_reset_mid_wait();
`ifdef STEP_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
